// File: rtl/hilo_unit.sv
// HI/LO register owner for the MIPS datapath: sequences divides and multiplies, services mthi/mtlo.
// Define HILO_FWD_EN to bypass committed/written values combinationally onto hi_out/lo_out.
module hilo_unit #(
    parameter int WIDTH        = 32,
    parameter int DIV_LATENCY  = 33,
    parameter int MULT_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic             mult_start,
    input  logic [WIDTH-1:0] div_hi,
    input  logic [WIDTH-1:0] div_lo,
    input  logic             div_zero,
    input  logic [WIDTH-1:0] mult_hi,
    input  logic [WIDTH-1:0] mult_lo,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             div_rst,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero_exc
);

    // The counter is shared by both wait states, so size it for the longer one.
    localparam int MAX_LAT = (DIV_LATENCY > MULT_LATENCY) ? DIV_LATENCY : MULT_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        DIV_RST,
        DIV_WAIT,
        MULT_WAIT,
        COMMIT
    } state_t;

    state_t             state_q, state_d;
    logic               op_div_q, op_div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_rst_q;

    always_comb begin
        state_d  = state_q;
        op_div_d = op_div_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (mthi) hi_d = wdata;
                if (mtlo) lo_d = wdata;
                if (div_start) begin
                    state_d  = DIV_RST;
                    op_div_d = 1'b1;
                end else if (mult_start) begin
                    state_d  = MULT_WAIT;
                    op_div_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            DIV_RST: begin
                cnt_d   = '0;
                state_d = DIV_WAIT;
            end
            DIV_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIV_LATENCY - 1)) state_d = COMMIT;
            end
            MULT_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MULT_LATENCY - 1)) state_d = COMMIT;
            end
            COMMIT: begin
                state_d = IDLE;
                // A zero-divisor divide leaves HI/LO untouched and only raises the exception.
                if (op_div_q) begin
                    if (!div_zero) begin
                        hi_d = div_hi;
                        lo_d = div_lo;
                    end
                end else begin
                    hi_d = mult_hi;
                    lo_d = mult_lo;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            op_div_q  <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            div_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_div_q  <= op_div_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            div_rst_q <= (state_d == DIV_RST);
        end
    end

    assign div_rst      = div_rst_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == COMMIT);
    assign div_zero_exc = (state_q == COMMIT) && op_div_q && div_zero;

`ifdef HILO_FWD_EN
    // hi_d/lo_d already carry the commit or mthi/mtlo value for this cycle.
    assign hi_out = hi_d;
    assign lo_out = lo_d;
`else
    assign hi_out = hi_q;
    assign lo_out = lo_q;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: commit expectations are queued at each start and
// compared when the unit reports done.
module tb_hilo_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             div_start, mult_start;
    logic [WIDTH-1:0] div_hi, div_lo, mult_hi, mult_lo, wdata;
    logic             div_zero, mthi, mtlo;
    logic             div_rst, busy, done, div_zero_exc;
    logic [WIDTH-1:0] hi_out, lo_out;

    hilo_unit #(.WIDTH(WIDTH), .DIV_LATENCY(33), .MULT_LATENCY(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .div_start   (div_start),
        .mult_start  (mult_start),
        .div_hi      (div_hi),
        .div_lo      (div_lo),
        .div_zero    (div_zero),
        .mult_hi     (mult_hi),
        .mult_lo     (mult_lo),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wdata       (wdata),
        .div_rst     (div_rst),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .busy        (busy),
        .done        (done),
        .div_zero_exc(div_zero_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        logic             exc;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             mon_e;
    int               n_checks = 0;
    int               n_pass   = 0;
    logic [WIDTH-1:0] model_hi = '0;
    logic [WIDTH-1:0] model_lo = '0;
    logic [WIDTH-1:0] prev_hi;
    int               nb, nr, nd;

    task automatic check_eq(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Scoreboard consumer: exception flag checked in COMMIT, HI/LO one edge later.
    always @(negedge clk) begin
        if (reset && done) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("div_zero_exc", {31'b0, div_zero_exc}, {31'b0, mon_e.exc});
                @(negedge clk);
                check_eq("hi_commit", hi_out, mon_e.hi);
                check_eq("lo_commit", lo_out, mon_e.lo);
                $display("commit hi=%h lo=%h exc=%0d", hi_out, lo_out, mon_e.exc);
            end
        end
    end

    task automatic push_div(input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] l, input logic z);
        exp_t e;
        if (!z) begin
            model_hi = h;
            model_lo = l;
        end
        e.hi  = model_hi;
        e.lo  = model_lo;
        e.exc = z;
        exp_q.push_back(e);
    endtask

    task automatic push_mul(input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] l);
        exp_t e;
        model_hi = h;
        model_lo = l;
        e.hi  = h;
        e.lo  = l;
        e.exc = 1'b0;
        exp_q.push_back(e);
    endtask

    // Counts busy/div_rst/done cycles until the unit returns to IDLE (bounded).
    task automatic wait_idle(output int busy_n, output int rst_n, output int done_n);
        busy_n = 0; rst_n = 0; done_n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            div_start = 1'b0; mult_start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            if (!busy) return;
            busy_n++;
            if (div_rst) rst_n++;
            if (done) done_n++;
        end
        check_eq("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_div(input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] l, input logic z,
                           input logic with_mult, input string tag);
        @(negedge clk);
        div_hi = h; div_lo = l; div_zero = z;
        div_start = 1'b1; mult_start = with_mult;
        push_div(h, l, z);
        wait_idle(nb, nr, nd);
        check_eq({tag, "_busy_cycles"}, nb, 35);
        check_eq({tag, "_div_rst_cycles"}, nr, 1);
        check_eq({tag, "_done_cycles"}, nd, 1);
        $display("div %s: busy=%0d div_rst=%0d done=%0d", tag, nb, nr, nd);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        div_start = 1'b0; mult_start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        div_hi = '0; div_lo = '0; div_zero = 1'b0; mult_hi = '0; mult_lo = '0; wdata = '0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_hi", hi_out, 32'd0);
        check_eq("rst_lo", lo_out, 32'd0);
        check_eq("rst_done", {31'b0, done}, 32'd0);
        check_eq("rst_div_rst", {31'b0, div_rst}, 32'd0);
        reset = 1'b1;
        $display("reset released");

        run_div(32'd2, 32'd14, 1'b0, 1'b0, "div100_7");
        run_div(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, "divneg7_2");

        // Preset HI=5, LO=6, then a zero-divisor divide must leave them alone.
        @(negedge clk); mthi = 1'b1; wdata = 32'd5;
        @(negedge clk); mthi = 1'b0; mtlo = 1'b1; wdata = 32'd6;
        @(negedge clk); mtlo = 1'b0;
        model_hi = 32'd5; model_lo = 32'd6;
        check_eq("preset_hi", hi_out, 32'd5);
        check_eq("preset_lo", lo_out, 32'd6);
        $display("preset hi=%h lo=%h", hi_out, lo_out);
        run_div(32'd99, 32'd98, 1'b1, 1'b0, "divzero");
        div_zero = 1'b0;

        // Both starts together: divide wins.
        mult_hi = 32'd1; mult_lo = 32'd2;
        run_div(32'd7, 32'd8, 1'b0, 1'b1, "div_and_mult");

        @(negedge clk);
        mult_start = 1'b1;
        push_mul(32'd1, 32'd2);
        wait_idle(nb, nr, nd);
        check_eq("mult_busy_cycles", nb, 2);
        check_eq("mult_div_rst_cycles", nr, 0);
        $display("mult: busy=%0d div_rst=%0d done=%0d", nb, nr, nd);
        @(negedge clk);

        // mthi together with a start: write lands now, commit overwrites later.
        mult_hi = 32'd3; mult_lo = 32'd4;
        mthi = 1'b1; wdata = 32'hAA; mult_start = 1'b1;
        push_mul(32'd3, 32'd4);
        @(negedge clk);
        mthi = 1'b0; mult_start = 1'b0;
        check_eq("mthi_with_start", hi_out, 32'hAA);
        $display("mthi+mult_start hi=%h", hi_out);
        wait_idle(nb, nr, nd);
        @(negedge clk);

        // Reset while DIV_WAIT counter is 10: abort without commit.
        div_hi = 32'd11; div_lo = 32'd12; div_start = 1'b1;
        push_div(32'd11, 32'd12, 1'b0);
        @(negedge clk);
        div_start = 1'b0;
        repeat (11) @(negedge clk);
        reset = 1'b0;
        void'(exp_q.pop_back());
        model_hi = '0; model_lo = '0;
        #1;
        check_eq("abort_busy", {31'b0, busy}, 32'd0);
        check_eq("abort_hi", hi_out, 32'd0);
        check_eq("abort_lo", lo_out, 32'd0);
        check_eq("abort_done", {31'b0, done}, 32'd0);
        $display("abort busy=%0d hi=%h lo=%h", busy, hi_out, lo_out);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_div(32'd21, 32'd22, 1'b0, 1'b0, "after_abort");

        // mthi while busy is ignored.
        prev_hi = model_hi;
        div_hi = 32'd3; div_lo = 32'd4; div_start = 1'b1;
        push_div(32'd3, 32'd4, 1'b0);
        @(negedge clk);
        div_start = 1'b0;
        repeat (4) @(negedge clk);
        mthi = 1'b1; wdata = 32'hDEAD;
        @(negedge clk);
        mthi = 1'b0;
        check_eq("mthi_busy_hi", hi_out, prev_hi);
        $display("mthi while busy hi=%h", hi_out);
        wait_idle(nb, nr, nd);
        @(negedge clk);

        // mthi+mtlo in IDLE.
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234;
`ifdef HILO_FWD_EN
        #1;
        check_eq("fwd_hi", hi_out, 32'h1234);
        check_eq("fwd_lo", lo_out, 32'h1234);
`endif
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check_eq("mthilo_hi", hi_out, 32'h1234);
        check_eq("mthilo_lo", lo_out, 32'h1234);
        $display("mthi+mtlo hi=%h lo=%h", hi_out, lo_out);

        repeat (3) @(negedge clk);
        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Downstream consumer of the multicycle divider and the multiplier in the MIPS datapath; owns the architectural HI/LO registers.
- Sequences a divide: pulses the divider's reset, counts a fixed latency, then commits the divider's hi/lo or flags divide-by-zero.
- Also commits multiplier results and services mthi/mtlo writes.
- Drives busy to the control FSM, which must stall mfhi/mflo and new HI/LO ops while busy=1.

Parameters:
- WIDTH, 32, data width of HI, LO and all data ports.
- DIV_LATENCY, 33, cycles in DIV_WAIT after div_rst drops; divider outputs must be stable at the end of this window.
- MULT_LATENCY, 1, cycles in MULT_WAIT before multiplier outputs are sampled; must be >=1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- div_start  input  1  one-cycle request to start a divide.
- mult_start  input  1  one-cycle request to start a multiply.
- div_hi  input  WIDTH  divider remainder.
- div_lo  input  WIDTH  divider quotient.
- div_zero  input  1  divider divide-by-zero flag.
- mult_hi  input  WIDTH  multiplier upper product.
- mult_lo  input  WIDTH  multiplier lower product.
- mthi  input  1  write wdata to HI.
- mtlo  input  1  write wdata to LO.
- wdata  input  WIDTH  data for mthi/mtlo.
- div_rst  output  1  registered one-cycle restart pulse to the divider.
- hi_out  output  WIDTH  HI register value.
- lo_out  output  WIDTH  LO register value.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in the COMMIT state.
- div_zero_exc  output  1  one-cycle pulse in COMMIT when a divide hit a zero divisor.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - HI, LO and the counter clear to 0.
  - The op-type flag clears.
  - div_rst, busy, done and div_zero_exc go to 0.
  - Reset mid-operation aborts the operation with no commit. The divider must also receive the system reset.
- States: IDLE, DIV_RST, DIV_WAIT, MULT_WAIT, COMMIT.
- IDLE:
  - div_start=1 -> DIV_RST, with op flag=DIV.
  - Else mult_start=1 -> MULT_WAIT, with op flag=MUL and counter=0.
  - Both starts asserted together: divide wins and mult_start is dropped.
- DIV_RST: div_rst=1 for exactly this one cycle; counter=0; next state DIV_WAIT.
- DIV_WAIT: counter increments each cycle; when counter==DIV_LATENCY-1, next state COMMIT. The counter is $clog2(DIV_LATENCY+1) bits wide.
- MULT_WAIT: same as DIV_WAIT, using MULT_LATENCY.
- COMMIT: done=1 and busy=1, then next state IDLE. At the COMMIT clock edge:
  - Op DIV with div_zero=0: HI<=div_hi, LO<=div_lo.
  - Op DIV with div_zero=1: HI and LO are unchanged, and div_zero_exc=1 in COMMIT.
  - Op MUL: HI<=mult_hi, LO<=mult_lo.
- Latency (start sampled at edge E0):
  - Divide: busy is high for DIV_LATENCY+2 cycles, and the new HI/LO are visible after edge E0+DIV_LATENCY+2.
  - Multiply: busy is high for MULT_LATENCY+1 cycles.
- div_start/mult_start while busy=1 are ignored; there is no queueing.
- mthi/mtlo:
  - Honoured only in IDLE and ignored while busy.
  - Both asserted together: HI and LO both take wdata.
  - Asserted with a start in the same IDLE cycle: the write occurs, the start is accepted, and the later COMMIT overwrites.
- No arithmetic in this block; values pass through bit-exact.

Optional Feature:
- HILO_FWD_EN defined:
  - hi_out/lo_out are combinationally bypassed.
  - In COMMIT they show the value being committed (div_zero=1 shows the old HI/LO).
  - In IDLE with mthi/mtlo=1, the written half shows wdata.
  - This gives zero-cycle read-after-commit.
- Not defined: hi_out/lo_out are purely the registered HI/LO and update one edge after COMMIT or a write.

Test Plan:
- div_start with div_hi=2, div_lo=14 (100/7) -> div_rst high for 1 cycle; busy high 35 cycles; done pulse; HI=2, LO=14; div_zero_exc=0.
- div_start with div_lo=32'hFFFFFFFD, div_hi=32'hFFFFFFFF (-7/2) -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF after commit.
- HI=5, LO=6 preset via mthi/mtlo, then div_start with div_zero=1 -> div_zero_exc pulses with done; HI stays 5, LO stays 6.
- mult_start and div_start in the same cycle, mult_hi=1, mult_lo=2 -> divide sequence runs (div_rst pulses); mult ignored; a later standalone mult_start commits HI=1, LO=2 after 2 busy cycles.
- reset low at DIV_WAIT counter=10 -> immediately IDLE, busy=0, HI=LO=0; no done pulse; a new div_start after release completes normally.
- mthi with wdata=32'hDEAD while busy -> HI unchanged; mthi+mtlo with wdata=32'h1234 in IDLE -> HI=LO=32'h1234. With HILO_FWD_EN, hi_out=32'h1234 in the same cycle.
